// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Shared types and constants for the multicycle instruction fetch stage:
// FSM state encoding, fault cause encoding, memory response payload and the
// reset value of the instruction register.
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int unsigned INSN_W  = 32;
    localparam int unsigned CAUSE_W = 2;

    // addi x0, x0, 0 -- harmless instruction presented out of reset
    localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_VALID = 3'd2,
        S_DRAIN = 3'd3,
        S_FAULT = 3'd4
    } fetch_state_e;

    typedef enum logic [CAUSE_W-1:0] {
        F_NONE     = 2'b00,
        F_MISALIGN = 2'b01,
        F_BUS      = 2'b10,
        F_TIMEOUT  = 2'b11
    } fault_cause_e;

    // Response side of the instruction memory handshake
    typedef struct packed {
        logic              ack;
        logic              err;
        logic [INSN_W-1:0] rdata;
    } imem_rsp_t;

    // Instruction fetches must be 32-bit aligned
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_watchdog.sv
// ---------------------------------------------------------------------------
// fetch_watchdog
// Bounds the number of cycles the fetch FSM spends waiting for a memory ack.
// The counter clears when the FSM enters a waiting state, advances on every
// waiting cycle without an ack and saturates at TIMEOUT_CYCLES.
//
// Ports:
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   clear_i      restart the count (entry into a waiting state)
//   enable_i     FSM is currently waiting for an ack
//   ack_i        memory ack this cycle (an ack always beats a timeout)
//   expired_c_o  combinational: this is the last allowed cycle and no ack came
// ---------------------------------------------------------------------------
module fetch_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    input  logic ack_i,
    output logic expired_c_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating count of ack-less waiting cycles
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !ack_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The edge that would bring the count to TIMEOUT_CYCLES is the timeout edge
    assign expired_c_o = enable_i && !ack_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Multicycle instruction fetch stage. A fetch request issues one 32-bit read
// over a req/ack handshake, the returned word is captured in the instruction
// register and announced with a one-cycle valid pulse. Misaligned PCs, bus
// errors and (optionally) memory timeouts are reported as sticky faults that
// are cleared by flush.
//
// Build option:
//   FETCH_TIMEOUT_EN  when defined, a watchdog bounds WAIT/DRAIN to
//                     TIMEOUT_CYCLES cycles and fault cause 11 becomes
//                     reachable; otherwise the FSM waits indefinitely.
//
// Ports:
//   clk_i               clock, rising edge
//   reset_ni            synchronous active-low reset
//   fetch_req_i         start a fetch of pc_i (honoured in IDLE only)
//   pc_i                fetch address
//   flush_i             abandon current fetch / clear a fault
//   imem_req_o          memory read request (registered)
//   imem_addr_o         read address, stable while imem_req_o is high
//   imem_ack_i          memory completes the read this cycle
//   imem_err_i          marks the ack as a bus error
//   imem_rdata_i        read data, valid with imem_ack_i
//   instruction_out_o   instruction register
//   instr_valid_o       one-cycle pulse: instruction register newly loaded
//   busy_o              high in every state except IDLE
//   fault_o             sticky fault flag
//   fault_cause_o       00 none, 01 misaligned, 10 bus error, 11 timeout
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               fetch_req_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic               flush_i,
    output logic               imem_req_o,
    output logic [XLEN-1:0]    imem_addr_o,
    input  logic               imem_ack_i,
    input  logic               imem_err_i,
    input  logic [INSN_W-1:0]  imem_rdata_i,
    output logic [INSN_W-1:0]  instruction_out_o,
    output logic               instr_valid_o,
    output logic               busy_o,
    output logic               fault_o,
    output logic [CAUSE_W-1:0] fault_cause_o
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT_CYCLES must be at least 1");
    end

    fetch_state_e      state_q, state_d;
    logic              imem_req_q, imem_req_d;
    logic [XLEN-1:0]   imem_addr_q, imem_addr_d;
    logic [INSN_W-1:0] instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              busy_q, busy_d;
    logic              fault_q, fault_d;
    fault_cause_e      cause_q, cause_d;

    imem_rsp_t         rsp_c;
    logic              timeout_c;

    assign rsp_c = {imem_ack_i, imem_err_i, imem_rdata_i};

`ifdef FETCH_TIMEOUT_EN
    logic wd_clear_c;
    logic wd_enable_c;

    // Count restarts on every entry into WAIT or DRAIN (including WAIT->DRAIN)
    always_comb begin
        wd_enable_c = (state_q == S_WAIT) || (state_q == S_DRAIN);
        wd_clear_c  = (state_d != state_q) && ((state_d == S_WAIT) || (state_d == S_DRAIN));
    end

    fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i       (clk_i),
        .rst_ni      (reset_ni),
        .clear_i     (wd_clear_c),
        .enable_i    (wd_enable_c),
        .ack_i       (rsp_c.ack),
        .expired_c_o (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        fault_d       = fault_q;
        cause_d       = cause_q;

        unique case (state_q)
            S_IDLE: begin
                // flush beats a simultaneous request
                if (!flush_i && fetch_req_i) begin
                    if (is_word_aligned(pc_i[1:0])) begin
                        imem_addr_d = pc_i;
                        imem_req_d  = 1'b1;
                        state_d     = S_WAIT;
                    end else begin
                        fault_d = 1'b1;
                        cause_d = F_MISALIGN;
                        state_d = S_FAULT;
                    end
                end
            end

            S_WAIT: begin
                if (rsp_c.ack) begin
                    imem_req_d = 1'b0;
                    if (flush_i) begin
                        // transaction retired, data dropped
                        state_d = S_IDLE;
                    end else if (rsp_c.err) begin
                        fault_d = 1'b1;
                        cause_d = F_BUS;
                        state_d = S_FAULT;
                    end else begin
                        instr_d       = rsp_c.rdata;
                        instr_valid_d = 1'b1;
                        state_d       = S_VALID;
                    end
                end else if (flush_i) begin
                    // request stays up until memory answers
                    state_d = S_DRAIN;
                end else if (timeout_c) begin
                    imem_req_d = 1'b0;
                    fault_d    = 1'b1;
                    cause_d    = F_TIMEOUT;
                    state_d    = S_FAULT;
                end
            end

            S_VALID: begin
                state_d = S_IDLE;
            end

            S_DRAIN: begin
                // any ack (error or not) ends the drain; a timeout abandons it quietly
                if (rsp_c.ack || timeout_c) begin
                    imem_req_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end

            S_FAULT: begin
                if (flush_i) begin
                    fault_d = 1'b0;
                    cause_d = F_NONE;
                    state_d = S_IDLE;
                end
            end

            default: begin
                imem_req_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q       <= S_IDLE;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= '0;
            instr_q       <= NOP_INSN;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            fault_q       <= 1'b0;
            cause_q       <= F_NONE;
        end else begin
            state_q       <= state_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            busy_q        <= busy_d;
            fault_q       <= fault_d;
            cause_q       <= cause_d;
        end
    end

    assign imem_req_o        = imem_req_q;
    assign imem_addr_o       = imem_addr_q;
    assign instruction_out_o = instr_q;
    assign instr_valid_o     = instr_valid_q;
    assign busy_o            = busy_q;
    assign fault_o           = fault_q;
    assign fault_cause_o     = cause_q;

endmodule
